// File: rtl/gate_exerciser_pkg.sv
// Shared types and helpers for the gate exerciser.
// Define GATE_EXERCISER_GRAY_EN to sweep vectors in Gray-code order instead of binary.
package gate_exerciser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        FIN    = 2'd3
    } state_e;

    localparam int unsigned MAX_N_IN = 8;

    function automatic int unsigned n_vec(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

    // Gray order toggles exactly one gate input per step.
    function automatic logic [MAX_N_IN-1:0] idx_to_vec(input logic [MAX_N_IN-1:0] idx);
`ifdef GATE_EXERCISER_GRAY_EN
        return idx ^ (idx >> 1);
`else
        return idx;
`endif
    endfunction

endpackage

// File: rtl/gate_vec_seq.sv
// Sweep index counter; vec is the registered mapped vector, so it is 0 whenever cleared.
module gate_vec_seq
    import gate_exerciser_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            advance,
    output logic [N_IN-1:0] vec,
    output logic            last
);

    logic [N_IN-1:0] idx_q, idx_d;
    logic [N_IN-1:0] vec_q, vec_d;

    always_comb begin
        idx_d = idx_q;
        if (clear) begin
            idx_d = '0;
        end else if (advance) begin
            idx_d = idx_q + N_IN'(1);
        end
        vec_d = N_IN'(idx_to_vec(MAX_N_IN'(idx_d)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            vec_q <= '0;
        end else begin
            idx_q <= idx_d;
            vec_q <= vec_d;
        end
    end

    assign vec  = vec_q;
    assign last = (idx_q == '1);

endmodule

// File: rtl/gate_exerciser.sv
// Sweeps all input vectors of a combinational block, checks each response against a latched truth table.
// Sweep order is binary, or Gray when GATE_EXERCISER_GRAY_EN is defined.
module gate_exerciser
    import gate_exerciser_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [n_vec(N_IN)-1:0] truth_table,
    output logic [N_IN-1:0]        dut_in,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_IN:0]          err_count,
    output logic [N_IN-1:0]        fail_vec
);

    localparam int unsigned N_VEC = n_vec(N_IN);

    state_e           state_q, state_d;
    logic [7:0]       settle_q, settle_d;
    logic [N_VEC-1:0] table_q, table_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [N_IN:0]    err_q, err_d;
    logic [N_IN-1:0]  fail_q, fail_d;
    logic             seq_clear, seq_adv, seq_last, mismatch;

    gate_vec_seq #(.N_IN(N_IN)) u_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (seq_clear),
        .advance (seq_adv),
        .vec     (dut_in),
        .last    (seq_last)
    );

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        table_d   = table_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        err_d     = err_q;
        fail_d    = fail_q;
        seq_clear = 1'b0;
        seq_adv   = 1'b0;
        mismatch  = (dut_out != table_q[dut_in]);
        case (state_q)
            IDLE: begin
                if (start) begin
                    table_d   = truth_table;
                    err_d     = '0;
                    fail_d    = '0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
                    settle_d  = 8'(SETTLE);
                    seq_clear = 1'b1;
                    state_d   = APPLY;
                end
            end
            APPLY: begin
                if (settle_q == 8'd0) state_d = SAMPLE;
                else                  settle_d = settle_q - 8'd1;
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + (N_IN+1)'(1);
                    if (err_q == '0) fail_d = dut_in;
                end
                // Clearing the sequencer on the last vector returns dut_in to 0 in FIN.
                if (seq_last) begin
                    seq_clear = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    pass_d    = (err_d == '0);
                    state_d   = FIN;
                end else begin
                    seq_adv  = 1'b1;
                    settle_d = 8'(SETTLE);
                    state_d  = APPLY;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            settle_q <= '0;
            table_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            fail_q   <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            table_q  <= table_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule
